// File: rtl/issue_scoreboard.sv
// ---------------------------------------------------------------------------
// ariane_pkg (minimal): entry and exception records shared by the scoreboard
// and its neighbours.
//
// issue_scoreboard
//   Circular buffer of NR_ENTRIES scoreboard entries. Instructions enter in
//   order at the tail (slot index = trans_id), receive results out of order
//   from NR_WB_PORTS writeback ports, and retire in order from the head.
//   Also answers rs1/rs2 operand lookups against in-flight producers.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   flush_i                       drop every in-flight entry
//   full_o                        all slots occupied
//   decoded_instr_i/_valid_i      issue request, decoded_ack_o accepts it
//   issue_trans_id_o              slot the next issue lands in (tail)
//   wb_valid_i/_trans_id_i/
//   wb_data_i/wb_ex_i             per-port writeback
//   commit_instr_o/_valid_o       head entry, ready to retire
//   commit_ack_i                  retire the head
//   rsX_i -> rsX_o/_valid_o/_busy_o  operand forwarding lookup
// ---------------------------------------------------------------------------
package ariane_pkg;
    localparam int unsigned SB_TRANS_ID_W = 8;
    localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0]              pc;
        logic [SB_TRANS_ID_W-1:0] trans_id;
        logic [3:0]               fu;
        logic [6:0]               op;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        logic                     use_imm;
        exception_t               ex;
    } scoreboard_entry;
endpackage

module issue_scoreboard
    import ariane_pkg::*;
#(
    parameter int unsigned NR_ENTRIES    = 8,
    parameter int unsigned NR_WB_PORTS   = 4,
    localparam int unsigned TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       flush_i,
    output logic                                       full_o,
    input  scoreboard_entry                            decoded_instr_i,
    input  logic                                       decoded_valid_i,
    output logic                                       decoded_ack_o,
    output logic [TRANS_ID_BITS-1:0]                   issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                     wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]  wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][63:0]               wb_data_i,
    input  exception_t [NR_WB_PORTS-1:0]               wb_ex_i,
    output scoreboard_entry                            commit_instr_o,
    output logic                                       commit_valid_o,
    input  logic                                       commit_ack_i,
    input  logic [4:0]                                 rs1_i,
    input  logic [4:0]                                 rs2_i,
    output logic [63:0]                                rs1_o,
    output logic [63:0]                                rs2_o,
    output logic                                       rs1_valid_o,
    output logic                                       rs2_valid_o,
    output logic                                       rs1_busy_o,
    output logic                                       rs2_busy_o
);

    localparam int unsigned WB_SEL_W = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;
    localparam logic [TRANS_ID_BITS-1:0] ONE_ID   = TRANS_ID_BITS'(1);
    localparam logic [TRANS_ID_BITS:0]   ONE_CNT  = (TRANS_ID_BITS+1)'(1);
    localparam logic [TRANS_ID_BITS:0]   FULL_CNT = (TRANS_ID_BITS+1)'(NR_ENTRIES);

    scoreboard_entry                mem [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]          occupied;
    logic [TRANS_ID_BITS-1:0]       head, tail;
    // One extra bit so a full buffer (head == tail) differs from an empty one.
    logic [TRANS_ID_BITS:0]         count;

    logic                           issue, commit;
    logic [NR_ENTRIES-1:0]          wb_hit;
    logic [NR_ENTRIES-1:0][WB_SEL_W-1:0] wb_sel;
    logic                           wb_conflict;

    // full_o is registered state only: a commit in the same cycle never
    // frees a slot for an issue (no bypass). Reset also blocks acceptance
    // so every output reads 0 while rst_i is held.
    assign full_o           = (count == FULL_CNT);
    assign issue            = decoded_valid_i & ~full_o & ~flush_i & ~rst_i;
    assign decoded_ack_o    = issue;
    assign issue_trans_id_o = tail;

    assign commit_instr_o   = mem[head];
    assign commit_valid_o   = (count != '0) & mem[head].valid;
    assign commit           = commit_ack_i & commit_valid_o;

    // Per-slot writeback select. Ports are scanned high to low so the
    // lowest-indexed port hitting a slot is the one that sticks.
    always_comb begin
        wb_hit      = '0;
        wb_sel      = '0;
        wb_conflict = 1'b0;
        for (int s = 0; s < NR_ENTRIES; s++) begin
            for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
                if (wb_valid_i[p] && wb_trans_id_i[p] == TRANS_ID_BITS'(s)) begin
                    if (wb_hit[s]) wb_conflict = 1'b1;
                    wb_hit[s] = 1'b1;
                    wb_sel[s] = WB_SEL_W'(p);
                end
            end
        end
    end

    // Operand lookup: walk oldest to youngest over the occupied range so the
    // last match seen is the youngest producer. x0 never matches.
    always_comb begin
        rs1_o = '0; rs1_valid_o = 1'b0; rs1_busy_o = 1'b0;
        rs2_o = '0; rs2_valid_o = 1'b0; rs2_busy_o = 1'b0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if ((TRANS_ID_BITS+1)'(i) < count) begin
                if (rs1_i != '0 && mem[head + TRANS_ID_BITS'(i)].rd == rs1_i) begin
                    rs1_valid_o = mem[head + TRANS_ID_BITS'(i)].valid;
                    rs1_busy_o  = ~mem[head + TRANS_ID_BITS'(i)].valid;
                    rs1_o       = mem[head + TRANS_ID_BITS'(i)].valid ?
                                  mem[head + TRANS_ID_BITS'(i)].result : '0;
                end
                if (rs2_i != '0 && mem[head + TRANS_ID_BITS'(i)].rd == rs2_i) begin
                    rs2_valid_o = mem[head + TRANS_ID_BITS'(i)].valid;
                    rs2_busy_o  = ~mem[head + TRANS_ID_BITS'(i)].valid;
                    rs2_o       = mem[head + TRANS_ID_BITS'(i)].valid ?
                                  mem[head + TRANS_ID_BITS'(i)].result : '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            occupied <= '0;
            for (int s = 0; s < NR_ENTRIES; s++) mem[s] <= '0;
        end else if (flush_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            occupied <= '0;
            for (int s = 0; s < NR_ENTRIES; s++) mem[s].valid <= 1'b0;
        end else begin
            // The issue slot is never occupied, so writebacks (which need an
            // occupied target) and the issue write cannot collide.
            for (int s = 0; s < NR_ENTRIES; s++) begin
                if (wb_hit[s] && occupied[s]) begin
                    mem[s].result <= wb_data_i[wb_sel[s]];
                    mem[s].valid  <= 1'b1;
                    if (wb_ex_i[wb_sel[s]].valid) mem[s].ex <= wb_ex_i[wb_sel[s]];
                end
            end
            if (issue) begin
                mem[tail]          <= decoded_instr_i;
                mem[tail].trans_id <= SB_TRANS_ID_W'(tail);
                // Faulting instructions have nothing to wait for.
                mem[tail].valid    <= decoded_instr_i.ex.valid;
                occupied[tail]     <= 1'b1;
                tail               <= tail + ONE_ID;
            end
            if (commit) begin
                occupied[head] <= 1'b0;
                head           <= head + ONE_ID;
            end
            if (issue && !commit)      count <= count + ONE_CNT;
            else if (!issue && commit) count <= count - ONE_CNT;
        end
    end

    // Two ports targeting the same slot in one cycle is a protocol error.
    wb_port_conflict: assert property (@(posedge clk_i) disable iff (rst_i) !wb_conflict);

endmodule
